// File: rtl/fp_add_sequencer_pkg.sv
// fpadd_seq_pkg: shared types and helpers for the adder sequencer.
// Holds the FSM state enum plus width and saturation helper functions.
package fpadd_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ALIGN,
      SR,
      SL,
      PASS,
      RENORM,
      DONE
   } state_t;

   function automatic int idx_w(input int n);
      return $clog2(n);
   endfunction

   function automatic int sat_min(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/fp_add_sequencer_if.sv
// fp_add_sequencer_if: operand/result valid-ready handshakes.
// master = producer/consumer side, slave = sequencer side.
interface fp_add_sequencer_if;

   logic InValid;
   logic InReady;
   logic OutValid;
   logic OutReady;

   modport master (
      output InValid,
      output OutReady,
      input  InReady,
      input  OutValid
   );

   modport slave (
      input  InValid,
      input  OutReady,
      output InReady,
      output OutValid
   );

endinterface

// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: control FSM for the adder (align, normalise,
// round, renormalise). Ports: Clock, Reset (sync, active-high),
// hs (InValid/InReady/OutValid/OutReady), datapath status inputs
// and Moore control outputs. Macro FPADD_EXC_FLAGS_EN adds the
// Overflow/Underflow flag outputs.
module fp_add_sequencer
   import fpadd_seq_pkg::*;
#(
   parameter int EXPBITS      = 8,
   parameter int MANTISSABITS = 23,
   parameter int GRSBITS      = 3,
   localparam int IDXW = idx_w(MANTISSABITS + 2),
   localparam int SHW  = idx_w(MANTISSABITS + GRSBITS + 2)
) (
   input  logic               Clock,
   input  logic               Reset,
   fp_add_sequencer_if.slave  hs,
   input  logic               ExpAGe,
   input  logic [EXPBITS-1:0] ExpDiff,
   input  logic [EXPBITS-1:0] ResultExp,
   input  logic               FFOValid,
   input  logic [IDXW-1:0]    FFOIndex,
   input  logic               RoundCarry,
   output logic               SelExpMux,
   output logic               SelAlignA,
   output logic               SelAlignB,
   output logic               AlignEn,
   output logic [SHW-1:0]     AlignAmount,
   output logic               NormSREn,
   output logic               NormSLEn,
   output logic               NormPass,
   output logic [IDXW-1:0]    NormShiftAmount,
   output logic               SelRoundMux,
`ifdef FPADD_EXC_FLAGS_EN
   output logic               Overflow,
   output logic               Underflow,
`endif
   output logic               ZeroResult
);

   localparam int HID   = MANTISSABITS;
   localparam int CRY   = MANTISSABITS + 1;
   localparam int ALMAX = MANTISSABITS + GRSBITS + 1;

   state_t state;
   logic   in_ready;
   logic   out_valid;

   // Alignment saturates so a huge ExpDiff cannot wrap the shifter
   logic [SHW-1:0] al_amt;
   assign al_amt = SHW'(sat_min(int'(ExpDiff), ALMAX));

   // Left shift never drops the exponent below 1
   int             sl_lim;
   int             sl_want;
   logic [IDXW-1:0] sl_amt;
   assign sl_lim  = (ResultExp == '0) ? 0 : int'(ResultExp) - 1;
   assign sl_want = HID - int'(FFOIndex);
   assign sl_amt  = IDXW'(sat_min(sl_want, sl_lim));

`ifdef FPADD_EXC_FLAGS_EN
   localparam logic [EXPBITS-1:0] EXP_OVF =
      {{(EXPBITS-1){1'b1}}, 1'b0};
   logic ovf_hit;
   logic sl_clamp;
   assign ovf_hit  = (ResultExp == EXP_OVF);
   assign sl_clamp = (sl_want > sl_lim);
`endif

   assign hs.InReady  = in_ready;
   assign hs.OutValid = out_valid;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state           <= IDLE;
         in_ready        <= 1'b1;
         out_valid       <= 1'b0;
         SelExpMux       <= 1'b0;
         SelAlignA       <= 1'b0;
         SelAlignB       <= 1'b0;
         AlignEn         <= 1'b0;
         AlignAmount     <= '0;
         NormSREn        <= 1'b0;
         NormSLEn        <= 1'b0;
         NormPass        <= 1'b0;
         NormShiftAmount <= '0;
         SelRoundMux     <= 1'b0;
         ZeroResult      <= 1'b0;
`ifdef FPADD_EXC_FLAGS_EN
         Overflow        <= 1'b0;
         Underflow       <= 1'b0;
`endif
      end else begin
         // Per-state outputs are rebuilt each cycle for the next state
         in_ready        <= 1'b0;
         out_valid       <= 1'b0;
         SelExpMux       <= 1'b0;
         SelAlignA       <= 1'b0;
         SelAlignB       <= 1'b0;
         AlignEn         <= 1'b0;
         AlignAmount     <= '0;
         NormSREn        <= 1'b0;
         NormSLEn        <= 1'b0;
         NormPass        <= 1'b0;
         NormShiftAmount <= '0;
         SelRoundMux     <= 1'b0;
         unique case (state)
            IDLE: begin
               if (hs.InValid) begin
                  state       <= ALIGN;
                  SelExpMux   <= ExpAGe;
                  SelAlignB   <= ExpAGe;
                  SelAlignA   <= !ExpAGe;
                  AlignEn     <= (ExpDiff != '0);
                  AlignAmount <= al_amt;
                  ZeroResult  <= 1'b0;
`ifdef FPADD_EXC_FLAGS_EN
                  Overflow    <= 1'b0;
                  Underflow   <= 1'b0;
`endif
               end else begin
                  in_ready <= 1'b1;
               end
            end
            ALIGN: begin
               unique case (1'b1)
                  !FFOValid: begin
                     state      <= PASS;
                     NormPass   <= 1'b1;
                     ZeroResult <= 1'b1;
                  end
                  FFOValid && FFOIndex == IDXW'(CRY): begin
                     state    <= SR;
                     NormSREn <= 1'b1;
`ifdef FPADD_EXC_FLAGS_EN
                     Overflow <= ovf_hit;
`endif
                  end
                  FFOValid && FFOIndex == IDXW'(HID): begin
                     state    <= PASS;
                     NormPass <= 1'b1;
                  end
                  FFOValid && FFOIndex < IDXW'(HID): begin
                     state           <= SL;
                     NormSLEn        <= 1'b1;
                     NormShiftAmount <= sl_amt;
`ifdef FPADD_EXC_FLAGS_EN
                     Underflow       <= sl_clamp;
`endif
                  end
                  default: begin
                     state    <= PASS;
                     NormPass <= 1'b1;
                  end
               endcase
            end
            SR, SL, PASS: begin
               if (RoundCarry) begin
                  state       <= RENORM;
                  SelRoundMux <= 1'b1;
                  NormSREn    <= 1'b1;
`ifdef FPADD_EXC_FLAGS_EN
                  if (ovf_hit) Overflow <= 1'b1;
`endif
               end else begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            RENORM: begin
               state     <= DONE;
               out_valid <= 1'b1;
            end
            DONE: begin
               if (hs.OutReady) begin
                  state    <= IDLE;
                  in_ready <= 1'b1;
               end else begin
                  out_valid <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// tb_fp_add_sequencer: table vectors, hand sequences and random ops
// checked against a rule-level model of the sequencer.
module tb_fp_add_sequencer;

   localparam int K_PASS = 0;
   localparam int K_SR   = 1;
   localparam int K_SL   = 2;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       ExpAGe;
   logic [7:0] ExpDiff;
   logic [7:0] ResultExp;
   logic       FFOValid;
   logic [4:0] FFOIndex;
   logic       RoundCarry;
   logic       SelExpMux, SelAlignA, SelAlignB, AlignEn;
   logic [4:0] AlignAmount;
   logic       NormSREn, NormSLEn, NormPass;
   logic [4:0] NormShiftAmount;
   logic       SelRoundMux, ZeroResult;
`ifdef FPADD_EXC_FLAGS_EN
   logic       Overflow, Underflow;
`endif

   fp_add_sequencer_if hs ();

   fp_add_sequencer dut (
      .Clock(Clock), .Reset(Reset), .hs(hs),
      .ExpAGe(ExpAGe), .ExpDiff(ExpDiff), .ResultExp(ResultExp),
      .FFOValid(FFOValid), .FFOIndex(FFOIndex),
      .RoundCarry(RoundCarry), .SelExpMux(SelExpMux),
      .SelAlignA(SelAlignA), .SelAlignB(SelAlignB),
      .AlignEn(AlignEn), .AlignAmount(AlignAmount),
      .NormSREn(NormSREn), .NormSLEn(NormSLEn),
      .NormPass(NormPass), .NormShiftAmount(NormShiftAmount),
      .SelRoundMux(SelRoundMux),
`ifdef FPADD_EXC_FLAGS_EN
      .Overflow(Overflow), .Underflow(Underflow),
`endif
      .ZeroResult(ZeroResult)
   );

   always #5 Clock = ~Clock;

   logic [9:0] ctl;
   assign ctl = {hs.InReady, hs.OutValid, SelExpMux, SelAlignA,
                 SelAlignB, AlignEn, NormSREn, NormSLEn, NormPass,
                 SelRoundMux};

   typedef struct {
      bit       age;
      bit [7:0] diff;
      bit       ffov;
      bit [4:0] idx;
      bit [7:0] rexp;
      bit       carry;
      int       hold;
      int       e_align;
      int       e_kind;
      int       e_namt;
      bit       e_zero;
      bit       e_ovf;
      bit       e_unf;
   } vec_t;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   function automatic int mk(input bit ir, ov, se, sa, sb, en,
                             sr, sl, ps, rm);
      return int'({ir, ov, se, sa, sb, en, sr, sl, ps, rm});
   endfunction

   // Rule-level model: what the sequencer should do for one operation
   function automatic vec_t model(input vec_t v);
      int lim, want;
      v.e_align = (v.diff > 27) ? 27 : int'(v.diff);
      v.e_zero  = !v.ffov;
      v.e_namt  = 0;
      v.e_unf   = 0;
      if (!v.ffov) v.e_kind = K_PASS;
      else if (v.idx == 24) v.e_kind = K_SR;
      else if (v.idx < 23) v.e_kind = K_SL;
      else v.e_kind = K_PASS;
      if (v.e_kind == K_SL) begin
         lim  = (v.rexp == 0) ? 0 : int'(v.rexp) - 1;
         want = 23 - int'(v.idx);
         v.e_namt = (want < lim) ? want : lim;
         v.e_unf  = want > lim;
      end
      v.e_ovf = (v.e_kind == K_SR || v.carry) && v.rexp == 8'd254;
      return v;
   endfunction

   task automatic run_op(input vec_t v, input bit in_at_done);
      int dn, idle;
      dn   = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("idle", int'(ctl), idle);
      ExpAGe = v.age; ExpDiff = v.diff; FFOValid = v.ffov;
      FFOIndex = v.idx; ResultExp = v.rexp; RoundCarry = v.carry;
      hs.InValid = 1'b1;
      @(negedge Clock);
      hs.InValid = 1'b0;
      chk("align_ctl", int'(ctl),
          mk(0, 0, v.age, !v.age, v.age, v.diff != 0, 0, 0, 0, 0));
      chk("align_amt", int'(AlignAmount), v.e_align);
      @(negedge Clock);
      chk("norm_ctl", int'(ctl),
          mk(0, 0, 0, 0, 0, 0, v.e_kind == K_SR, v.e_kind == K_SL,
             v.e_kind == K_PASS, 0));
      if (v.e_kind == K_SL)
         chk("norm_amt", int'(NormShiftAmount), v.e_namt);
      if (v.carry) begin
         @(negedge Clock);
         chk("renorm_ctl", int'(ctl), mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
      end
      @(negedge Clock);
      chk("done_ctl", int'(ctl), dn);
      chk("zero", int'(ZeroResult), int'(v.e_zero));
`ifdef FPADD_EXC_FLAGS_EN
      chk("overflow", int'(Overflow), int'(v.e_ovf));
      chk("underflow", int'(Underflow), int'(v.e_unf));
`endif
      for (int i = 0; i < v.hold; i++) begin
         @(negedge Clock);
         chk("hold_ctl", int'(ctl), dn);
      end
      hs.OutReady = 1'b1;
      hs.InValid  = in_at_done;
      @(negedge Clock);
      hs.OutReady = 1'b0;
      chk("release", int'(ctl), idle);
   endtask

   vec_t tbl[9];
   vec_t rv;

   initial begin
      Reset = 1'b1; hs.InValid = 1'b0; hs.OutReady = 1'b0;
      ExpAGe = 1'b0; ExpDiff = '0; ResultExp = '0;
      FFOValid = 1'b0; FFOIndex = '0; RoundCarry = 1'b0;

      //        age diff ffov idx rexp c hold align kind  namt z ovf unf
      tbl[0] = '{1, 0,   1, 23, 100, 0, 0, 0,  K_PASS, 0, 0, 0, 0};
      tbl[1] = '{0, 200, 1, 23, 100, 0, 0, 27, K_PASS, 0, 0, 0, 0};
      tbl[2] = '{1, 5,   1, 24, 100, 1, 0, 5,  K_SR,   0, 0, 0, 0};
      tbl[3] = '{1, 3,   1, 5,  10,  0, 0, 3,  K_SL,   9, 0, 0, 1};
      tbl[4] = '{0, 27,  1, 20, 100, 0, 1, 27, K_SL,   3, 0, 0, 0};
      tbl[5] = '{1, 1,   0, 0,  50,  0, 5, 1,  K_PASS, 0, 1, 0, 0};
      tbl[6] = '{1, 28,  1, 5,  0,   0, 0, 27, K_SL,   0, 0, 0, 1};
      tbl[7] = '{0, 9,   1, 27, 60,  0, 0, 9,  K_PASS, 0, 0, 0, 0};
      tbl[8] = '{1, 2,   1, 24, 254, 0, 0, 2,  K_SR,   0, 0, 1, 0};

      @(negedge Clock);
      @(negedge Clock);
      chk("reset_ctl", int'(ctl), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      chk("reset_zero", int'(ZeroResult), 0);
      Reset = 1'b0;
      @(negedge Clock);

      for (int i = 0; i < 9; i++) run_op(tbl[i], 1'b0);

      // InValid during the DONE hand-off is only taken from IDLE
      rv = model('{1, 4, 1, 23, 80, 0, 0, 0, 0, 0, 0, 0, 0});
      run_op(rv, 1'b1);
      @(negedge Clock);
      hs.InValid = 1'b0;
      chk("late_accept", int'(ctl), mk(0, 0, 1, 0, 1, 1, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) @(negedge Clock);
      hs.OutReady = 1'b1;
      @(negedge Clock);
      hs.OutReady = 1'b0;
      chk("late_release", int'(ctl), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      // Reset while in SL drops the operation
      ExpAGe = 1'b1; ExpDiff = 8'd3; FFOValid = 1'b1;
      FFOIndex = 5'd5; ResultExp = 8'd50; RoundCarry = 1'b0;
      hs.InValid = 1'b1;
      @(negedge Clock);
      hs.InValid = 1'b0;
      @(negedge Clock);
      chk("in_sl", int'(NormSLEn), 1);
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      chk("rst_sl", int'(ctl), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      hs.OutReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge Clock);
         chk("rst_no_valid", int'(ctl), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      hs.OutReady = 1'b0;

      for (int i = 0; i < 60; i++) begin
         rv.age   = 1'($urandom_range(0, 1));
         rv.diff  = (i % 4 == 0) ? 8'($urandom_range(0, 255))
                                 : 8'($urandom_range(0, 30));
         rv.ffov  = $urandom_range(0, 7) != 0;
         rv.idx   = 5'($urandom_range(0, 31));
         rv.rexp  = (i % 5 == 0) ? 8'd254 : 8'($urandom_range(0, 255));
         rv.carry = 1'($urandom_range(0, 1));
         rv.hold  = $urandom_range(0, 2);
         run_op(model(rv), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
